// File: rtl/jam_cost_server.sv
// jam_cost_server: cost-table responder for the JAM job-assignment engine.
// Streams an N*N cost table in after reset, then answers {W,J} lookups with
// Cost one cycle later and captures the engine's final result on Valid.
//
// Optional feature macro: JAM_COST_ACCESS_CNT_EN (adds Access_Cnt profiling
// counter; absent when undefined).
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   Load_Valid/Data     streaming table load, row-major (w0j0 first)
//   Load_Ready          high while loading
//   Ready               table loaded, serving lookups
//   W, J                worker/job index, registered every serving cycle
//   Cost                mem[8*W_q + J_q]; 0 while loading
//   Valid, MinCost,
//   MatchCount          engine result strobe and payload
//   Res_MinCost,
//   Res_MatchCount      captured result (first Valid while serving)
//   Done                result captured, sticky until RST
//   Access_Cnt          (macro only) count of serving cycles with a new {W,J}
module jam_cost_server #(
  parameter int unsigned N      = 8,
  parameter int unsigned COST_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Load_Valid,
  input  logic [COST_W-1:0] Load_Data,
  output logic              Load_Ready,
  output logic              Ready,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [8:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic [8:0]        Res_MinCost,
  output logic [3:0]        Res_MatchCount,
  output logic              Done
`ifdef JAM_COST_ACCESS_CNT_EN
  ,
  output logic [15:0]       Access_Cnt
`endif
);

  localparam int unsigned DEPTH  = N * N;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [2:0]          W_q;
  logic [2:0]          J_q;
  logic [COST_W-1:0]   mem [DEPTH];

  // Control FSM with registered handshake/result outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= S_LOAD;
      cnt            <= '0;
      W_q            <= '0;
      J_q            <= '0;
      Load_Ready     <= 1'b1;
      Ready          <= 1'b0;
      Res_MinCost    <= '0;
      Res_MatchCount <= '0;
      Done           <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (Load_Valid) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == ADDR_W'(DEPTH - 1)) begin
              state      <= S_SERVE;
              Load_Ready <= 1'b0;
              Ready      <= 1'b1;
            end
          end
        end
        S_SERVE: begin
          W_q <= W;
          J_q <= J;
          if (Valid) begin
            Res_MinCost    <= MinCost;
            Res_MatchCount <= MatchCount;
            Done           <= 1'b1;
            state          <= S_DONE;
          end
        end
        S_DONE: begin
          // Keep serving so a late readback sees current costs
          W_q <= W;
          J_q <= J;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Table storage; deliberately not cleared by RST, next load overwrites it
  always_ff @(posedge CLK) begin
    if (state == S_LOAD && Load_Valid) begin
      mem[cnt] <= Load_Data;
    end
  end

  // Lookup is combinational from the registered indices
  assign Cost = (state == S_LOAD) ? '0 : mem[{W_q, J_q}];

`ifdef JAM_COST_ACCESS_CNT_EN
  // Counts serving cycles whose request differs from the held one; saturates
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Access_Cnt <= '0;
    end else if (state == S_SERVE && {W, J} != {W_q, J_q} &&
                 Access_Cnt != 16'hFFFF) begin
      Access_Cnt <= Access_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: table-driven lookups, full sweeps,
// randomized lookups against a reference table, result capture and reset cases.
module tb_jam_cost_server;

  logic       CLK;
  logic       RST;
  logic       Load_Valid;
  logic [6:0] Load_Data;
  logic       Load_Ready;
  logic       Ready;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       Valid;
  logic [8:0] MinCost;
  logic [3:0] MatchCount;
  logic [8:0] Res_MinCost;
  logic [3:0] Res_MatchCount;
  logic       Done;
`ifdef JAM_COST_ACCESS_CNT_EN
  logic [15:0] Access_Cnt;
`endif

  jam_cost_server dut (
    .CLK            (CLK),
    .RST            (RST),
    .Load_Valid     (Load_Valid),
    .Load_Data      (Load_Data),
    .Load_Ready     (Load_Ready),
    .Ready          (Ready),
    .W              (W),
    .J              (J),
    .Cost           (Cost),
    .Valid          (Valid),
    .MinCost        (MinCost),
    .MatchCount     (MatchCount),
    .Res_MinCost    (Res_MinCost),
    .Res_MatchCount (Res_MatchCount),
    .Done           (Done)
`ifdef JAM_COST_ACCESS_CNT_EN
    ,
    .Access_Cnt     (Access_Cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    logic [6:0] cost;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [6:0] ref_mem [64];
  logic [6:0] ld_data [64];
  bit         m_done;
  int         acc;
  logic [2:0] pw;
  logic [2:0] pj;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    Load_Valid = 1'b0;
    RST = 1'b1;
    #1;
    chk({nm, "_load_ready"}, 32'(Load_Ready), 1);
    chk({nm, "_ready"}, 32'(Ready), 0);
    chk({nm, "_cost"}, 32'(Cost), 0);
    chk({nm, "_res_min"}, 32'(Res_MinCost), 0);
    chk({nm, "_res_cnt"}, 32'(Res_MatchCount), 0);
    chk({nm, "_done"}, 32'(Done), 0);
`ifdef JAM_COST_ACCESS_CNT_EN
    chk({nm, "_acc"}, 32'(Access_Cnt), 0);
`endif
    m_done = 1'b0;
    acc = 0;
    pw = 3'd0;
    pj = 3'd0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Streams nwords of ld_data; with toggle, Load_Valid is low on even cycles
  task automatic load_words(input int nwords, input bit toggle, output int cycles);
    int n_acc;
    n_acc = 0;
    cycles = 0;
    while (n_acc < nwords && cycles < 400) begin
      Load_Valid = toggle ? (cycles % 2 == 1) : 1'b1;
      Load_Data  = Load_Valid ? ld_data[n_acc] : 7'($urandom);
      @(posedge CLK);
      #1;
      cycles++;
      if (Load_Valid) begin
        ref_mem[n_acc] = ld_data[n_acc];
        n_acc++;
      end
      if (n_acc < 64) chk("ready_low_during_load", 32'(Ready), 0);
    end
    Load_Valid = 1'b0;
    chk("load_accept_count", n_acc, nwords);
  endtask

  task automatic lookup(input logic [2:0] w, input logic [2:0] j,
                        input logic [6:0] exp, input string nm);
    W = w;
    J = j;
    Load_Valid = 1'($urandom);
    Load_Data  = 7'($urandom);
    @(posedge CLK);
    #1;
    if (!m_done && {w, j} != {pw, pj} && acc < 65535) acc++;
    pw = w;
    pj = j;
    chk(nm, 32'(Cost), 32'(exp));
  endtask

  task automatic sweep(input string nm);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        lookup(3'(w), 3'(j), ref_mem[8 * w + j], nm);
  endtask

  vec_t vecs [6];
  int   cyc;
  logic [2:0] rw;
  logic [2:0] rj;

  initial begin
    vecs[0] = '{3'd3, 3'd5, 7'd29};
    vecs[1] = '{3'd0, 3'd0, 7'd0};
    vecs[2] = '{3'd7, 3'd7, 7'd63};
    vecs[3] = '{3'd7, 3'd0, 7'd56};
    vecs[4] = '{3'd0, 3'd7, 7'd7};
    vecs[5] = '{3'd4, 3'd4, 7'd36};

    RST = 1'b1; Load_Valid = 1'b0; Load_Data = '0; W = '0; J = '0;
    Valid = 1'b0; MinCost = '0; MatchCount = '0;
    do_reset("rst0");

    // Back-to-back load of (8w+j)%128 with a stray Valid that must be ignored
    for (int i = 0; i < 64; i++) ld_data[i] = 7'(i % 128);
    Valid = 1'b1; MinCost = 9'd33; MatchCount = 4'd5;
    load_words(64, 1'b0, cyc);
    Valid = 1'b0;
    chk("b2b_cycles", cyc, 64);
    chk("b2b_ready", 32'(Ready), 1);
    chk("b2b_load_ready", 32'(Load_Ready), 0);
    chk("valid_in_load_done", 32'(Done), 0);
    chk("valid_in_load_res", 32'(Res_MinCost), 0);

    for (int i = 0; i < 6; i++) lookup(vecs[i].w, vecs[i].j, vecs[i].cost, "vec_cost");
    sweep("sweep_a");

    // Asynchronous reset while serving
    #2;
    do_reset("rst_serve");

    // Toggled load of random data
    for (int i = 0; i < 64; i++) ld_data[i] = 7'($urandom);
    load_words(64, 1'b1, cyc);
    chk("toggle_cycles", cyc, 128);
    chk("toggle_ready", 32'(Ready), 1);

    // Alternate (1,1)/(2,2) for 10 cycles, then hold 5
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) lookup(3'd1, 3'd1, ref_mem[9], "alt_cost");
      else            lookup(3'd2, 3'd2, ref_mem[18], "alt_cost");
    end
    for (int i = 0; i < 5; i++) lookup(3'd2, 3'd2, ref_mem[18], "hold_cost");
`ifdef JAM_COST_ACCESS_CNT_EN
    chk("acc_alt", 32'(Access_Cnt), 10);
`endif

    sweep("sweep_b");
    for (int i = 0; i < 100; i++) begin
      rw = 3'($urandom);
      rj = 3'($urandom);
      lookup(rw, rj, ref_mem[{rw, rj}], "rand_cost");
    end
`ifdef JAM_COST_ACCESS_CNT_EN
    chk("acc_rand", 32'(Access_Cnt), acc);
`endif

    // Result capture, then a second Valid that must not overwrite it
    chk("done_before_valid", 32'(Done), 0);
    Valid = 1'b1; MinCost = 9'd485; MatchCount = 4'd2;
    @(posedge CLK); #1;
    m_done = 1'b1;
    chk("cap_min", 32'(Res_MinCost), 485);
    chk("cap_cnt", 32'(Res_MatchCount), 2);
    chk("cap_done", 32'(Done), 1);
    Valid = 1'b0;
    @(posedge CLK); #1;
    Valid = 1'b1; MinCost = 9'd100; MatchCount = 4'd7;
    @(posedge CLK); #1;
    Valid = 1'b0;
    chk("second_min", 32'(Res_MinCost), 485);
    chk("second_cnt", 32'(Res_MatchCount), 2);
    chk("second_done", 32'(Done), 1);
    lookup(3'd6, 3'd1, ref_mem[49], "done_cost");
    lookup(3'd0, 3'd3, ref_mem[3], "done_cost");
`ifdef JAM_COST_ACCESS_CNT_EN
    chk("acc_frozen", 32'(Access_Cnt), acc);
`endif

    #2;
    do_reset("rst_done");

    // Partial load, reset mid-load, then a fresh full load
    for (int i = 0; i < 64; i++) ld_data[i] = 7'($urandom);
    load_words(30, 1'b0, cyc);
    #2;
    do_reset("rst_load");
    for (int i = 0; i < 64; i++) ld_data[i] = 7'($urandom);
    load_words(64, 1'b0, cyc);
    chk("reload_cycles", cyc, 64);
    chk("reload_ready", 32'(Ready), 1);
    sweep("sweep_d");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
